// File: rtl/uart_tx_ctrl_if.sv
// Bundle of the frame-controller signals: byte request side, serializer side and UART line.
// master = requester/serializer environment, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  Ser_Data;
   logic                  Ser_Done;
   logic                  Ser_En;
   logic [DATA_WIDTH-1:0] Ser_Word;
   logic                  TX_OUT;
   logic                  busy;
   logic                  tx_accept;
   logic                  tmo_err;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
      input  Ser_En, Ser_Word, TX_OUT, busy, tx_accept, tmo_err
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
      output Ser_En, Ser_Word, TX_OUT, busy, tx_accept, tmo_err
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, serializer-driven data, optional parity, stop bits.
// Ser_Word presents the latched byte to the serializer, which loads it while Ser_En is low.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int SER_TMO    = 12
) (
   input logic          clk,
   input logic          rst_n,
   uart_tx_ctrl_if.slave bus
);
   localparam int TMO_W = (SER_TMO > 2) ? $clog2(SER_TMO) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SER_TMO - 1);
   localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  parity_q;
   logic                  par_en_q;
   logic [1:0]            stop_cnt_q;
   logic [TMO_W-1:0]      tmo_cnt_q;
   logic                  tx_accept_q;
   logic                  tmo_err_q;

   logic stop_last;
   logic accept;
   logic tx_out;
   logic ser_en;

   assign stop_last = (state_q == STOP) && (stop_cnt_q == STOP_LAST);
   // The last stop cycle doubles as an acceptance slot so frames can run back to back.
   assign accept    = bus.Data_Valid && ((state_q == IDLE) || stop_last);

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         parity_q    <= 1'b0;
         par_en_q    <= 1'b0;
         stop_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         tx_accept_q <= 1'b0;
         tmo_err_q   <= 1'b0;
      end else begin
         tx_accept_q <= accept;
         if (accept) begin
            state_q   <= START;
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            parity_q  <= ^bus.P_DATA ^ bus.PAR_TYP;
            tmo_err_q <= 1'b0;
         end else begin
            case (state_q)
               START: begin
                  state_q   <= DATA;
                  tmo_cnt_q <= '0;
               end
               DATA: begin
                  // Ser_Done on the timeout cycle still counts as a normal finish.
                  if (bus.Ser_Done) begin
                     state_q    <= par_en_q ? PARITY : STOP;
                     stop_cnt_q <= '0;
                  end else if (tmo_cnt_q == TMO_LAST) begin
                     state_q    <= STOP;
                     stop_cnt_q <= '0;
                     tmo_err_q  <= 1'b1;
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + 1'b1;
                  end
               end
               PARITY: begin
                  state_q    <= STOP;
                  stop_cnt_q <= '0;
               end
               STOP: begin
                  if (stop_last) state_q <= IDLE;
                  else           stop_cnt_q <= stop_cnt_q + 2'd1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // NOTE: defaults first, so no path through the case leaves an output unassigned
   // and no latch is inferred.
   always_comb begin
      tx_out = 1'b1;
      ser_en = 1'b0;
      case (state_q)
         START: begin
            tx_out = 1'b0;
            ser_en = 1'b1;
         end
         DATA: begin
            tx_out = bus.Ser_Data;
            ser_en = 1'b1;
         end
         PARITY:  tx_out = parity_q;
         default: ;
      endcase
   end

   assign bus.TX_OUT    = tx_out;
   assign bus.Ser_En    = ser_en;
   assign bus.Ser_Word  = data_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.tx_accept = tx_accept_q;
   assign bus.tmo_err   = tmo_err_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frames are expanded into an expected per-cycle line trace
// from the framing rules, then replayed against the DUT.
module tb_uart_tx_ctrl;
   localparam int DW        = 8;
   localparam int STOP_BITS = 2;
   localparam int SER_TMO   = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_ctrl #(
      .DATA_WIDTH(DW),
      .STOP_BITS (STOP_BITS),
      .SER_TMO   (SER_TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // n_done: 1-based DATA cycle on which Ser_Done rises; 0 means never.
   typedef struct {
      logic [DW-1:0] data;
      bit            par_en;
      bit            par_typ;
      int            n_done;
   } frame_t;

   // exp = {TX_OUT, Ser_En, busy, tx_accept, tmo_err}
   typedef struct {
      logic          dv;
      logic [DW-1:0] pd;
      logic          pe;
      logic          pt;
      logic          sd;
      logic          sdone;
      logic [4:0]    exp;
      bit            wchk;
      logic [DW-1:0] word;
   } cyc_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   bit     exp_err  = 1'b0;
   frame_t frames[$];
   cyc_t   trace[$];

   function automatic void push(logic dv, logic [DW-1:0] pd, logic pe, logic pt,
                                logic sd, logic sdone, logic [4:0] exp,
                                bit wchk, logic [DW-1:0] word);
      cyc_t c;
      c.dv = dv; c.pd = pd; c.pe = pe; c.pt = pt;
      c.sd = sd; c.sdone = sdone; c.exp = exp; c.wchk = wchk; c.word = word;
      trace.push_back(c);
   endfunction

   function automatic logic rbit();
      return logic'($urandom_range(0, 1));
   endfunction

   // Cycle that must be ignored: optional junk request and junk Ser_Done.
   function automatic void push_ignored(bit noisy, logic sd, logic [4:0] exp,
                                        bit wchk, logic [DW-1:0] word);
      push(noisy ? rbit() : 1'b0, DW'($urandom), rbit(), rbit(), sd,
           noisy ? rbit() : 1'b0, exp, wchk, word);
   endfunction

   // Expand the queued frames into the expected line behaviour.
   function automatic void build_trace(bit b2b, bit noisy);
      trace.delete();
      for (int i = 0; i < frames.size(); i++) begin
         frame_t f = frames[i];
         bit     tmo = !(f.n_done >= 1 && f.n_done <= SER_TMO);
         int     ncyc = tmo ? SER_TMO : f.n_done;
         bit     chain = b2b && (i + 1 < frames.size());
         if (i == 0 || !b2b)
            push(1'b1, f.data, f.par_en, f.par_typ, rbit(), 1'b0,
                 {1'b1, 1'b0, 1'b0, 1'b0, exp_err}, 1'b0, '0);
         exp_err = 1'b0;
         push_ignored(noisy, rbit(), 5'b01110, 1'b1, f.data);
         for (int j = 0; j < ncyc; j++) begin
            logic sd = rbit();
            push(noisy ? rbit() : 1'b0, DW'($urandom), rbit(), rbit(), sd,
                 logic'(j == f.n_done - 1), {sd, 4'b1100}, 1'b1, f.data);
         end
         if (tmo) exp_err = 1'b1;
         if (f.par_en && !tmo)
            push_ignored(noisy, rbit(), {^f.data ^ f.par_typ, 3'b010, exp_err}, 1'b0, '0);
         for (int k = 0; k < STOP_BITS; k++) begin
            if (k == STOP_BITS - 1 && chain)
               push(1'b1, frames[i+1].data, frames[i+1].par_en, frames[i+1].par_typ,
                    rbit(), rbit(), {4'b1010, exp_err}, 1'b0, '0);
            else if (k == STOP_BITS - 1)
               push(1'b0, DW'($urandom), rbit(), rbit(), rbit(), rbit(),
                    {4'b1010, exp_err}, 1'b0, '0);
            else
               push_ignored(noisy, rbit(), {4'b1010, exp_err}, 1'b0, '0);
         end
      end
      push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b1000, exp_err}, 1'b0, '0);
   endfunction

   task automatic play(string tag, int limit);
      logic [4:0] got;
      for (int c = 0; c < trace.size() && c < limit; c++) begin
         @(negedge clk);
         bus.Data_Valid = trace[c].dv;
         bus.P_DATA     = trace[c].pd;
         bus.PAR_EN     = trace[c].pe;
         bus.PAR_TYP    = trace[c].pt;
         bus.Ser_Data   = trace[c].sd;
         bus.Ser_Done   = trace[c].sdone;
         #1;
         got = {bus.TX_OUT, bus.Ser_En, bus.busy, bus.tx_accept, bus.tmo_err};
         n_checks++;
         if (got !== trace[c].exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d {tx,en,busy,acc,err}: got %b expected %b",
                     tag, c, got, trace[c].exp);
         end
         if (trace[c].wchk) begin
            n_checks++;
            if (bus.Ser_Word !== trace[c].word) begin
               n_fail++;
               $display("FAIL %s cycle %0d Ser_Word: got %h expected %h",
                        tag, c, bus.Ser_Word, trace[c].word);
            end
         end
      end
   endtask

   function automatic frame_t mk(logic [DW-1:0] d, bit pe, bit pt, int nd);
      frame_t f;
      f.data = d; f.par_en = pe; f.par_typ = pt; f.n_done = nd;
      return f;
   endfunction

   task automatic idle_inputs();
      bus.Data_Valid = 1'b0; bus.P_DATA = '0; bus.PAR_EN = 1'b0;
      bus.PAR_TYP = 1'b0; bus.Ser_Data = 1'b0; bus.Ser_Done = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      idle_inputs();
      #3;
      got = {bus.TX_OUT, bus.Ser_En, bus.busy, bus.tx_accept, bus.tmo_err};
      n_checks++;
      if (got !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_hold: got %b expected 10000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.Ser_Done = rbit();
         bus.Ser_Data = rbit();
         #1;
         got = {bus.TX_OUT, bus.Ser_En, bus.busy, bus.tx_accept, bus.tmo_err};
         n_checks++;
         if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL idle cycle %0d: got %b expected 10000", c, got);
         end
      end
      bus.Ser_Done = 1'b0;
   endtask

   task automatic test_parity();
      frames = '{mk(8'hA5, 1, 0, 8), mk(8'hA5, 1, 1, 8),
                 mk(DW'($urandom), 1, 0, $urandom_range(1, SER_TMO)),
                 mk(DW'($urandom), 1, 1, $urandom_range(1, SER_TMO))};
      build_trace(1'b0, 1'b1);
      play("parity", trace.size());
   endtask

   task automatic test_no_parity();
      frames = '{mk(8'h3C, 0, 0, 8), mk(DW'($urandom), 0, 1, 1)};
      build_trace(1'b0, 1'b0);
      play("no_parity", trace.size());
   endtask

   task automatic test_back_to_back();
      frames = '{mk(8'h01, 1, 0, 8), mk(8'h80, 1, 1, 8)};
      build_trace(1'b1, 1'b1);
      play("b2b", trace.size());
      frames.delete();
      for (int i = 0; i < 6; i++)
         frames.push_back(mk(DW'($urandom), bit'($urandom_range(0, 1)),
                             bit'($urandom_range(0, 1)), $urandom_range(1, SER_TMO)));
      build_trace(1'b1, 1'b1);
      play("b2b_rand", trace.size());
   endtask

   task automatic test_timeout();
      frames = '{mk(8'h5A, 1, 0, 0), mk(8'h77, 1, 1, 4)};
      build_trace(1'b0, 1'b1);
      play("tmo_clear", trace.size());
      frames = '{mk(8'hC3, 1, 0, SER_TMO), mk(8'h0F, 0, 0, SER_TMO + 1),
                 mk(8'hF0, 1, 1, 2)};
      build_trace(1'b1, 1'b1);
      play("tmo_edge", trace.size());
   endtask

   task automatic test_async_reset();
      logic [4:0] got;
      frames = '{mk(8'h96, 1, 0, 8)};
      build_trace(1'b0, 1'b0);
      play("pre_reset", 5);
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      got = {bus.TX_OUT, bus.Ser_En, bus.busy, bus.tx_accept, bus.tmo_err};
      n_checks++;
      if (got !== 5'b10000) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected 10000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_err = 1'b0;
      frames = '{mk(8'h69, 1, 1, 8)};
      build_trace(1'b0, 1'b1);
      play("post_reset", trace.size());
   endtask

   initial begin
      test_reset();
      test_parity();
      test_no_parity();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
